// File: rtl/ann_layer_engine.sv
// ann_layer_engine: three-layer fully-connected inference engine.
// A single bank of MAX_NODES signed MAC lanes is reused for every layer.
// The image is latched at start, weights stream in one input column per
// coefficient handshake, hidden layers apply ReLU and the final layer is
// reduced to a class index by a sequential argmax.
module ann_layer_engine #(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8,
  parameter int IMAGE_SIZE = 16,
  parameter int L1_NODES   = 16,
  parameter int L2_NODES   = 8,
  parameter int L3_NODES   = 10,
  parameter int MAX_NODES  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [IMAGE_SIZE*DATA_W-1:0]    image,
  output logic                            coef_req,
  output logic [1:0]                      coef_layer,
  output logic [$clog2(MAX_NODES)-1:0]    coef_index,
  input  logic                            coef_valid,
  input  logic [MAX_NODES*DATA_W-1:0]     coef_in,
  output logic                            busy,
  output logic                            done,
  output logic [3:0]                      class_out,
  output logic [L3_NODES*DATA_W-1:0]      out_vec
);

  localparam int IDX_W  = $clog2(MAX_NODES);
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + IDX_W + 1;
  localparam int ARG_W  = (L3_NODES > 1) ? $clog2(L3_NODES) : 1;

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_HI =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Lane count and class index width must cover every layer.
  generate
    if (MAX_NODES < IMAGE_SIZE || MAX_NODES < L1_NODES ||
        MAX_NODES < L2_NODES   || MAX_NODES < L3_NODES ||
        L3_NODES > 16) begin : g_bad_params
      $error("ann_layer_engine: MAX_NODES too small for configured layers");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_ACT,
    S_ARGMAX,
    S_DONE
  } state_t;

  state_t                    state;
  logic [1:0]                layer;
  logic [IDX_W-1:0]          k_idx;
  logic [ARG_W-1:0]          arg_idx;
  logic signed [DATA_W-1:0]  act_reg [MAX_NODES];
  logic signed [ACC_W-1:0]   acc     [MAX_NODES];
  logic signed [DATA_W-1:0]  out_reg [L3_NODES];
  logic signed [DATA_W-1:0]  best_val;
  logic [ARG_W-1:0]          best_idx;
  logic                      coef_req_r;
  logic                      busy_r;
  logic                      done_r;
  logic [3:0]                class_r;

  // Combinational helpers.
  int                        nodes_cur;
  int                        inputs_cur;
  logic signed [DATA_W-1:0]  act_k;
  logic signed [PROD_W-1:0]  prod    [MAX_NODES];
  logic signed [DATA_W-1:0]  act_new [MAX_NODES];
  logic signed [DATA_W-1:0]  cur_val;
  logic                      take_new;
  logic [ARG_W-1:0]          next_best_idx;

  // Clamp a shifted accumulator into the signed word range.
  function automatic logic signed [DATA_W-1:0] sat_word(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI)
      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < SAT_LO)
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return v[DATA_W-1:0];
  endfunction

  // Per-layer fan-in and fan-out.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path leaves it unassigned and infers a latch.
    nodes_cur  = L3_NODES;
    inputs_cur = L2_NODES;
    case (layer)
      2'd0: begin
        nodes_cur  = L1_NODES;
        inputs_cur = IMAGE_SIZE;
      end
      2'd1: begin
        nodes_cur  = L2_NODES;
        inputs_cur = L1_NODES;
      end
      default: begin
        nodes_cur  = L3_NODES;
        inputs_cur = L2_NODES;
      end
    endcase
  end

  // One MAC product per lane for the current input column.
  always_comb begin
    act_k = act_reg[k_idx];
    for (int n = 0; n < MAX_NODES; n++) begin
      prod[n] = act_k * $signed(coef_in[n*DATA_W +: DATA_W]);
    end
  end

  // Activation of each lane: rescale, saturate, ReLU on hidden layers.
  always_comb begin
    for (int n = 0; n < MAX_NODES; n++) begin
      logic signed [ACC_W-1:0]  shifted;
      logic signed [DATA_W-1:0] v;
      shifted = acc[n] >>> FRAC_W;
      v       = sat_word(shifted);
      if (layer != 2'd2 && v[DATA_W-1])
        v = '0;
      act_new[n] = (n < nodes_cur) ? v : '0;
    end
  end

  // Argmax step: strict greater-than keeps the lowest index on ties.
  always_comb begin
    cur_val       = out_reg[arg_idx];
    take_new      = (arg_idx == '0) || (cur_val > best_val);
    next_best_idx = take_new ? arg_idx : best_idx;
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      layer      <= 2'd0;
      k_idx      <= '0;
      arg_idx    <= '0;
      best_val   <= '0;
      best_idx   <= '0;
      coef_req_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      class_r    <= 4'd0;
      // NOTE: these arrays are small register banks, not RAM, and their reset value is observable, so they are cleared here.
      for (int n = 0; n < MAX_NODES; n++) begin
        act_reg[n] <= '0;
        acc[n]     <= '0;
      end
      for (int n = 0; n < L3_NODES; n++) begin
        out_reg[n] <= '0;
      end
    end else if (abort) begin
      // Abort overrides every transition; results from the last run stay.
      state      <= S_IDLE;
      coef_req_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state  <= S_LOAD;
            busy_r <= 1'b1;
          end
        end

        S_LOAD: begin
          for (int n = 0; n < MAX_NODES; n++) begin
            act_reg[n] <= (n < IMAGE_SIZE) ? $signed(image[n*DATA_W +: DATA_W]) : '0;
            acc[n]     <= '0;
          end
          layer      <= 2'd0;
          k_idx      <= '0;
          coef_req_r <= 1'b1;
          state      <= S_FETCH;
        end

        S_FETCH: begin
          if (coef_req_r && coef_valid) begin
            for (int n = 0; n < MAX_NODES; n++) begin
              if (n < nodes_cur)
                acc[n] <= acc[n] + {{(ACC_W-PROD_W){prod[n][PROD_W-1]}}, prod[n]};
            end
            if (int'(k_idx) == inputs_cur - 1) begin
              k_idx      <= '0;
              coef_req_r <= 1'b0;
              state      <= S_ACT;
            end else begin
              k_idx <= k_idx + 1'b1;
            end
          end
        end

        S_ACT: begin
          for (int n = 0; n < MAX_NODES; n++) begin
            act_reg[n] <= act_new[n];
            acc[n]     <= '0;
          end
          if (layer == 2'd2) begin
            for (int n = 0; n < L3_NODES; n++) begin
              out_reg[n] <= act_new[n];
            end
            arg_idx <= '0;
            state   <= S_ARGMAX;
          end else begin
            layer      <= layer + 2'd1;
            coef_req_r <= 1'b1;
            state      <= S_FETCH;
          end
        end

        S_ARGMAX: begin
          if (take_new) begin
            best_val <= cur_val;
            best_idx <= arg_idx;
          end
          if (int'(arg_idx) == L3_NODES - 1) begin
            class_r <= 4'(next_best_idx);
            done_r  <= 1'b1;
            state   <= S_DONE;
          end else begin
            arg_idx <= arg_idx + 1'b1;
          end
        end

        S_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state      <= S_IDLE;
          coef_req_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    coef_req   = coef_req_r;
    coef_layer = layer;
    coef_index = k_idx;
    busy       = busy_r;
    done       = done_r;
    class_out  = class_r;
    for (int n = 0; n < L3_NODES; n++) begin
      out_vec[n*DATA_W +: DATA_W] = out_reg[n];
    end
  end

endmodule

// File: tb/tb_ann_layer_engine.sv
// tb_ann_layer_engine: directed bench for ann_layer_engine with a
// coefficient responder that can stall every Nth request by three cycles.
module tb_ann_layer_engine;

  localparam int DW = 16;
  localparam int IS = 16;
  localparam int MN = 16;
  localparam int L3 = 10;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic [IS*DW-1:0]  image;
  logic              coef_req;
  logic [1:0]        coef_layer;
  logic [3:0]        coef_index;
  logic              coef_valid;
  logic [MN*DW-1:0]  coef_in;
  logic              busy;
  logic              done;
  logic [3:0]        class_out;
  logic [L3*DW-1:0]  out_vec;

  int checks = 0;
  int errors = 0;

  // Weight pattern: 0 all +1.0, 1 all -1.0, 2 routes image[3] to class 7.
  int w_mode = 0;
  int stall_every = 0;
  int req_count;
  int stall_left;

  ann_layer_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .image      (image),
    .coef_req   (coef_req),
    .coef_layer (coef_layer),
    .coef_index (coef_index),
    .coef_valid (coef_valid),
    .coef_in    (coef_in),
    .busy       (busy),
    .done       (done),
    .class_out  (class_out),
    .out_vec    (out_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] weight(int mode, int lyr, int n, int k);
    case (mode)
      0: return 16'h0100;
      1: return 16'hFF00;
      default: begin
        if (lyr == 0) return (n == k) ? 16'h0100 : 16'h0000;
        if (lyr == 1) return (n == 0 && k == 3) ? 16'h0100 : 16'h0000;
        return (n == 7 && k == 0) ? 16'h0100 : 16'h0000;
      end
    endcase
  endfunction

  always_comb begin
    for (int n = 0; n < MN; n++)
      coef_in[n*DW +: DW] = weight(w_mode, int'(coef_layer), n, int'(coef_index));
  end

  assign coef_valid = coef_req && (stall_left == 0);

  // Responder: request index i (from 0 per inference) waits 3 cycles when i % stall_every == 0.
  always @(posedge clk) begin
    if (!busy) begin
      req_count  <= 0;
      stall_left <= (stall_every != 0) ? 3 : 0;
    end else if (coef_req && coef_valid) begin
      req_count  <= req_count + 1;
      stall_left <= (stall_every != 0 && ((req_count + 1) % stall_every) == 0) ? 3 : 0;
    end else if (coef_req && stall_left > 0) begin
      stall_left <= stall_left - 1;
    end
  end

  task automatic set_image(input logic [DW-1:0] fill, input int sel, input logic [DW-1:0] sel_val);
    for (int k = 0; k < IS; k++)
      image[k*DW +: DW] = (k == sel) ? sel_val : fill;
  endtask

  // Pulse start, then count edges from the one that samples start until done.
  task automatic run_inference(input int busy_start_at, input bit scramble, output int cyc);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); cyc = 1; #1 start = 1'b0;
    while (done !== 1'b1 && cyc < 1000) begin
      @(posedge clk); cyc++; #1;
      start = (cyc == busy_start_at);
      if (scramble && cyc == 3) set_image(16'h7FFF, -1, 16'h0000);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, coef_req} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: busy/done/req=%b want 000", {busy, done, coef_req});
    end
    checks++;
    if (class_out !== 4'd0) begin
      errors++; $display("FAIL reset_class: got %0d want 0", class_out);
    end
    checks++;
    if (out_vec !== '0) begin
      errors++; $display("FAIL reset_out_vec: got %h want 0", out_vec);
    end
  endtask

  task automatic check_result(input string name, input int cyc, input int exp_cyc,
                              input logic [DW-1:0] exp_out [L3], input logic [3:0] exp_class);
    checks++;
    if (cyc !== exp_cyc) begin
      errors++; $display("FAIL %s_latency: got %0d want %0d", name, cyc, exp_cyc);
    end
    for (int i = 0; i < L3; i++) begin
      checks++;
      if (out_vec[i*DW +: DW] !== exp_out[i]) begin
        errors++; $display("FAIL %s_out[%0d]: got %h want %h", name, i, out_vec[i*DW +: DW], exp_out[i]);
      end
    end
    checks++;
    if (class_out !== exp_class) begin
      errors++; $display("FAIL %s_class: got %0d want %0d", name, class_out, exp_class);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL %s_done_pulse: done/busy=%b want 00", name, {done, busy});
    end
  endtask

  task automatic test_all_ones;
    logic [DW-1:0] exp [L3];
    int cyc;
    for (int i = 0; i < L3; i++) exp[i] = 16'h7FFF;
    w_mode = 0; stall_every = 0;
    set_image(16'h0100, -1, 16'h0000);
    run_inference(0, 1'b0, cyc);
    check_result("all_ones", cyc, 55, exp, 4'd0);
  endtask

  task automatic test_identity;
    logic [DW-1:0] exp [L3];
    int cyc;
    for (int i = 0; i < L3; i++) exp[i] = (i == 7) ? 16'h0280 : 16'h0000;
    w_mode = 2; stall_every = 0;
    set_image(16'h0000, 3, 16'h0280);
    run_inference(0, 1'b1, cyc);
    check_result("identity", cyc, 55, exp, 4'd7);
  endtask

  task automatic test_relu_negative;
    logic [DW-1:0] exp [L3];
    int cyc;
    for (int i = 0; i < L3; i++) exp[i] = 16'h0000;
    w_mode = 1; stall_every = 0;
    set_image(16'h0100, -1, 16'h0000);
    run_inference(0, 1'b0, cyc);
    check_result("relu_neg", cyc, 55, exp, 4'd0);
  endtask

  task automatic test_stall;
    logic [DW-1:0] exp [L3];
    int cyc;
    for (int i = 0; i < L3; i++) exp[i] = 16'h7FFF;
    w_mode = 0; stall_every = 4;
    set_image(16'h0100, -1, 16'h0000);
    run_inference(0, 1'b0, cyc);
    check_result("stall", cyc, 85, exp, 4'd0);
    stall_every = 0;
  endtask

  task automatic test_abort;
    logic [DW-1:0] exp [L3];
    int guard;
    int cyc;
    bit saw_done;
    w_mode = 2; stall_every = 0;
    set_image(16'h0000, 3, 16'h0280);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    guard = 0;
    while (!(coef_req === 1'b1 && coef_layer === 2'd1 && coef_index === 4'd5) && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    checks++;
    if (guard >= 200) begin
      errors++; $display("FAIL abort_reach_layer2: got timeout want layer-2 fetch");
    end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    checks++;
    if ({busy, coef_req, done} !== 3'b000) begin
      errors++; $display("FAIL abort_idle: busy/req/done=%b want 000", {busy, coef_req, done});
    end
    saw_done = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++; $display("FAIL abort_no_done: got activity after abort want none");
    end
    checks++;
    if (out_vec[7*DW +: DW] !== 16'h7FFF || out_vec[0 +: DW] !== 16'h7FFF) begin
      errors++; $display("FAIL abort_retain: got %h want all 7fff", out_vec);
    end
    for (int i = 0; i < L3; i++) exp[i] = (i == 7) ? 16'h0280 : 16'h0000;
    run_inference(0, 1'b0, cyc);
    check_result("abort_restart", cyc, 55, exp, 4'd7);
  endtask

  task automatic test_busy_start;
    logic [DW-1:0] exp [L3];
    int cyc;
    for (int i = 0; i < L3; i++) exp[i] = 16'h7FFF;
    w_mode = 0; stall_every = 0;
    set_image(16'h0100, -1, 16'h0000);
    run_inference(20, 1'b0, cyc);
    check_result("busy_start", cyc, 55, exp, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_start_restart: busy=%b want 0", busy);
    end
  endtask

  task automatic test_rst_argmax;
    w_mode = 2; stall_every = 0;
    set_image(16'h0000, 3, 16'h0280);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    // Edge 1 sampled start; after edge 50 the engine is mid-argmax.
    repeat (49) @(posedge clk);
    #1;
    checks++;
    if (out_vec[7*DW +: DW] !== 16'h0280 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_argmax_pre: out7=%h busy=%b want 0280 1", out_vec[7*DW +: DW], busy);
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++;
    if ({busy, done, coef_req} !== 3'b000) begin
      errors++; $display("FAIL rst_argmax_ctrl: busy/done/req=%b want 000", {busy, done, coef_req});
    end
    checks++;
    if (out_vec !== '0 || class_out !== 4'd0) begin
      errors++; $display("FAIL rst_argmax_out: out=%h class=%0d want 0 0", out_vec, class_out);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    image = '0;
    test_reset();
    test_all_ones();
    test_identity();
    test_relu_negative();
    test_stall();
    test_abort();
    test_busy_start();
    test_rst_argmax();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
